// File: rtl/mac_conv_ctrl.sv
// mac_conv_ctrl: sequences a pipelined signed MAC through a 1-D valid convolution
// y[j] = sum_{k<M} x[j+k]*w[k], j = 0..N-M. Each result leaves on a valid/ready stream.
// Completion of a dot product is detected by counting M MAC output strobes, so the
// controller is independent of the MAC pipeline depth.
module mac_conv_ctrl #(
  parameter int N   = 16,
  parameter int M   = 4,
  parameter int DW  = 14,
  parameter int XAW = 4,
  parameter int WAW = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   x_rd_en,
  output logic [XAW-1:0]         x_addr,
  input  logic signed [DW-1:0]   x_rdata,
  output logic                   w_rd_en,
  output logic [WAW-1:0]         w_addr,
  input  logic signed [DW-1:0]   w_rdata,
  output logic                   mac_reset,
  output logic signed [DW-1:0]   mac_a,
  output logic signed [DW-1:0]   mac_b,
  output logic                   mac_valid_in,
  input  logic signed [2*DW-1:0] mac_f,
  input  logic                   mac_valid_out,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic signed [2*DW-1:0] y_data,
  output logic [XAW-1:0]         y_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  // Last output index, last tap index and last expected MAC strobe (count from 0).
  localparam logic [XAW-1:0] J_LAST = XAW'(N - M);
  localparam logic [WAW-1:0] K_LAST = WAW'(M - 1);
  localparam logic [WAW:0]   V_LAST = (WAW + 1)'(M - 1);

  state_t              state_q, state_d;
  logic [XAW-1:0]      j_q, j_d;
  logic [WAW-1:0]      k_q, k_d;
  logic [WAW:0]        vcnt_q, vcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [XAW-1:0]      x_addr_q, x_addr_d;
  logic [WAW-1:0]      w_addr_q, w_addr_d;
  logic                mac_reset_q, mac_reset_d;
  logic                mac_valid_in_q, mac_valid_in_d;
  logic                y_valid_q, y_valid_d;
  logic [2*DW-1:0]     y_data_q, y_data_d;
  logic [XAW-1:0]      y_idx_q, y_idx_d;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d        = state_q;
    j_d            = j_q;
    k_d            = k_q;
    vcnt_d         = vcnt_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    rd_en_d        = rd_en_q;
    x_addr_d       = x_addr_q;
    w_addr_d       = w_addr_q;
    mac_reset_d    = mac_reset_q;
    // Memory data lands one cycle after the read, so the MAC strobe trails the read enable.
    mac_valid_in_d = rd_en_q;
    y_valid_d      = y_valid_q;
    y_data_d       = y_data_q;
    y_idx_d        = y_idx_q;

    case (state_q)
      S_IDLE: begin
        mac_reset_d = 1'b1;
        rd_en_d     = 1'b0;
        if (start) begin
          state_d = S_CLEAR;
          j_d     = {XAW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: begin
        // MAC is held in reset this cycle; first read pair is issued next cycle.
        k_d         = {WAW{1'b0}};
        vcnt_d      = {(WAW + 1){1'b0}};
        state_d     = S_FEED;
        rd_en_d     = 1'b1;
        x_addr_d    = j_q;
        w_addr_d    = {WAW{1'b0}};
        mac_reset_d = 1'b0;
      end

      S_FEED: begin
        vcnt_d = vcnt_q + {{WAW{1'b0}}, mac_valid_out};
        if (k_q == K_LAST) begin
          rd_en_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          k_d      = k_q + WAW'(1);
          x_addr_d = j_q + XAW'(k_q) + XAW'(1);
          w_addr_d = k_q + WAW'(1);
        end
      end

      S_DRAIN: begin
        if (mac_valid_out) begin
          if (vcnt_q == V_LAST) begin
            // Final accumulation of this dot product: capture it for the output stream.
            y_data_d  = mac_f;
            y_idx_d   = j_q;
            y_valid_d = 1'b1;
            state_d   = S_OUT;
          end else begin
            vcnt_d = vcnt_q + (WAW + 1)'(1);
          end
        end else begin
          vcnt_d = vcnt_q;
        end
      end

      S_OUT: begin
        if (y_ready) begin
          y_valid_d   = 1'b0;
          mac_reset_d = 1'b1;
          if (j_q == J_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            j_d     = j_q + XAW'(1);
            state_d = S_CLEAR;
          end
        end else begin
          state_d = S_OUT;
        end
      end

      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        rd_en_d     = 1'b0;
        mac_reset_d = 1'b1;
        y_valid_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; asynchronous reset aborts any conversion at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      j_q            <= {XAW{1'b0}};
      k_q            <= {WAW{1'b0}};
      vcnt_q         <= {(WAW + 1){1'b0}};
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      x_addr_q       <= {XAW{1'b0}};
      w_addr_q       <= {WAW{1'b0}};
      mac_reset_q    <= 1'b1;
      mac_valid_in_q <= 1'b0;
      y_valid_q      <= 1'b0;
      y_data_q       <= {(2 * DW){1'b0}};
      y_idx_q        <= {XAW{1'b0}};
    end else begin
      state_q        <= state_d;
      j_q            <= j_d;
      k_q            <= k_d;
      vcnt_q         <= vcnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      rd_en_q        <= rd_en_d;
      x_addr_q       <= x_addr_d;
      w_addr_q       <= w_addr_d;
      mac_reset_q    <= mac_reset_d;
      mac_valid_in_q <= mac_valid_in_d;
      y_valid_q      <= y_valid_d;
      y_data_q       <= y_data_d;
      y_idx_q        <= y_idx_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign x_rd_en      = rd_en_q;
  assign w_rd_en      = rd_en_q;
  assign x_addr       = x_addr_q;
  assign w_addr       = w_addr_q;
  assign mac_reset    = mac_reset_q;
  assign mac_valid_in = mac_valid_in_q;
  assign mac_a        = x_rdata;
  assign mac_b        = w_rdata;
  assign y_valid      = y_valid_q;
  assign y_data       = y_data_q;
  assign y_idx        = y_idx_q;

endmodule
